// File: rtl/execute_if.sv
// execute_if: the decode -> execute -> writeback signal bundle.
//   master : the surrounding pipeline (drives decoded *_i, observes stall_o and *_o)
//   slave  : the execute stage (consumes *_i, drives stall_o and *_o)
interface execute_if;
  // decoded instruction from decode
  logic        regWrite_i;
  logic        wdSrc_i;
  logic        branch_i;
  logic        condZero_i;
  logic        aluSrc_i;
  logic [2:0]  aluControl_i;
  logic [4:0]  rd_i;
  logic [31:0] rd1_i;
  logic [31:0] rd2_i;
  logic [31:0] immI_i;
  logic [31:0] immB_i;
  logic [31:0] immU_i;
  logic [31:0] pc_i;

  // upstream hold request
  logic        stall_o;

  // results captured by writeback
  logic        regWrite_o;
  logic        wdSrc_o;
  logic        branch_o;
  logic        condZero_o;
  logic        aluZero_o;
  logic [4:0]  rd_o;
  logic [31:0] immU_o;
  logic [31:0] aluResult_o;
  logic [31:0] pcBranch_o;
  logic [31:0] pcPlus4_o;

  modport master (
    output regWrite_i, wdSrc_i, branch_i, condZero_i, aluSrc_i, aluControl_i,
           rd_i, rd1_i, rd2_i, immI_i, immB_i, immU_i, pc_i,
    input  stall_o, regWrite_o, wdSrc_o, branch_o, condZero_o, aluZero_o,
           rd_o, immU_o, aluResult_o, pcBranch_o, pcPlus4_o
  );

  modport slave (
    input  regWrite_i, wdSrc_i, branch_i, condZero_i, aluSrc_i, aluControl_i,
           rd_i, rd1_i, rd2_i, immI_i, immB_i, immU_i, pc_i,
    output stall_o, regWrite_o, wdSrc_o, branch_o, condZero_o, aluZero_o,
           rd_o, immU_o, aluResult_o, pcBranch_o, pcPlus4_o
  );
endinterface

// File: rtl/execute.sv
// execute: execute stage of the pipelined schoolRISCV core.
//   Registers the decoded instruction, computes ALU result, branch target and
//   PC+4 for writeback. MUL (aluControl 3'b101) runs as a 32-step shift-add,
//   holding upstream via stall_o and presenting bubbles to writeback meanwhile.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous active-high reset
//   ex   - execute_if.slave: decoded *_i inputs, stall_o, writeback-facing *_o
// Parameters:
//   MUL_EN - 1 enables iterative MUL; 0 makes MUL return 0 with no stall
module execute #(
  parameter bit MUL_EN = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  execute_if.slave  ex
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [OP_W-1:0] OP_SRL  = 3'b010;
  localparam logic [OP_W-1:0] OP_SLTU = 3'b011;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b100;
  localparam logic [OP_W-1:0] OP_MUL  = 3'b101;

  localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

  typedef struct packed {
    logic            regWrite;
    logic            wdSrc;
    logic            branch;
    logic            condZero;
    logic            aluSrc;
    logic [OP_W-1:0] aluControl;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] immI;
    logic [XLEN-1:0] immB;
    logic [XLEN-1:0] immU;
    logic [XLEN-1:0] pc;
  } stageT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  stageT            stage;
  stateT            state;
  stateT            stateNext;
  logic             stall;
  logic             isMul;
  logic [XLEN-1:0]  srcA;
  logic [XLEN-1:0]  srcB;
  logic [XLEN-1:0]  aluResult;

  logic [XLEN-1:0]  acc;
  logic [XLEN-1:0]  mcand;
  logic [XLEN-1:0]  mplier;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  accNext;
  logic [XLEN-1:0]  mcandNext;
  logic [XLEN-1:0]  mplierNext;
  logic [CNT_W-1:0] cntNext;

  // Stage register: capture when not stalled, reset wins over hold and capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
    end else if (!stall) begin
      stage.regWrite   <= ex.regWrite_i;
      stage.wdSrc      <= ex.wdSrc_i;
      stage.branch     <= ex.branch_i;
      stage.condZero   <= ex.condZero_i;
      stage.aluSrc     <= ex.aluSrc_i;
      stage.aluControl <= ex.aluControl_i;
      stage.rd         <= ex.rd_i;
      stage.rd1        <= ex.rd1_i;
      stage.rd2        <= ex.rd2_i;
      stage.immI       <= ex.immI_i;
      stage.immB       <= ex.immB_i;
      stage.immU       <= ex.immU_i;
      stage.pc         <= ex.pc_i;
    end
  end

  // Operand selection from the registered instruction.
  assign srcA  = stage.rd1;
  assign srcB  = stage.aluSrc ? stage.immI : stage.rd2;
  assign isMul = MUL_EN && (stage.aluControl == OP_MUL);

  // MUL FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Multiplier datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      acc    <= accNext;
      mcand  <= mcandNext;
      mplier <= mplierNext;
      cnt    <= cntNext;
    end
  end

  // MUL FSM next-state, stall and shift-add step.
  // stall depends only on state and the registered opcode, never on *_i.
  always_comb begin
    stateNext  = state;
    stall      = 1'b0;
    accNext    = acc;
    mcandNext  = mcand;
    mplierNext = mplier;
    cntNext    = cnt;
    case (state)
      IDLE: begin
        if (isMul) begin
          stall      = 1'b1;
          stateNext  = BUSY;
          accNext    = '0;
          mcandNext  = srcA;
          mplierNext = srcB;
          cntNext    = '0;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mplier[0]) begin
          accNext = XLEN'(acc + mcand);
        end
        mcandNext  = XLEN'(mcand << 1);
        mplierNext = mplier >> 1;
        cntNext    = CNT_W'(cnt + CNT_W'(1));
        if (cnt == CNT_LAST) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        // one result cycle, the stage register reloads on the next edge
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // ALU; MUL reports the accumulator, which only matters in DONE.
  always_comb begin
    aluResult = '0;
    case (stage.aluControl)
      OP_ADD:  aluResult = XLEN'(srcA + srcB);
      OP_OR:   aluResult = srcA | srcB;
      OP_SRL:  aluResult = srcA >> srcB[4:0];
      OP_SLTU: aluResult = XLEN'(srcA < srcB);
      OP_SUB:  aluResult = XLEN'(srcA - srcB);
      OP_MUL:  aluResult = MUL_EN ? acc : '0;
      default: aluResult = '0;
    endcase
  end

  // Writeback-facing outputs; a stall cycle is a bubble with writes and branches masked.
  assign ex.stall_o     = stall;
  assign ex.regWrite_o  = stage.regWrite & ~stall;
  assign ex.branch_o    = stage.branch & ~stall;
  assign ex.wdSrc_o     = stage.wdSrc;
  assign ex.condZero_o  = stage.condZero;
  assign ex.rd_o        = stage.rd;
  assign ex.immU_o      = stage.immU;
  assign ex.aluResult_o = aluResult;
  assign ex.aluZero_o   = (aluResult == '0);
  assign ex.pcBranch_o  = XLEN'(stage.pc + stage.immB);
  assign ex.pcPlus4_o   = XLEN'(stage.pc + XLEN'(4));

endmodule

// File: tb/tb_execute.sv
// tb_execute: self-checking bench for execute. Two instances share clk/rst:
// dut (MUL_EN=1) and dut0 (MUL_EN=0). Expected values come from a
// per-instruction arithmetic model of each op plus the documented MUL latency.
module tb_execute;

  typedef struct {
    logic        rw;
    logic        wds;
    logic        br;
    logic        cz;
    logic        asrc;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] immI;
    logic [31:0] immB;
    logic [31:0] immU;
    logic [31:0] pc;
  } inT;

  typedef struct {
    logic        stall;
    logic        rw;
    logic        wds;
    logic        br;
    logic        cz;
    logic        zero;
    logic [4:0]  rd;
    logic [31:0] immU;
    logic [31:0] res;
    logic [31:0] pcBr;
    logic [31:0] pc4;
  } outT;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  execute_if ifc ();
  execute_if ifc0 ();

  execute #(.MUL_EN(1'b1)) dut  (.clk(clk), .rst(rst), .ex(ifc.slave));
  execute #(.MUL_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .ex(ifc0.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: plain arithmetic on the operation's definition.
  function automatic logic [31:0] refAlu(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input bit mulEn);
    logic [63:0] p;
    case (op)
      3'd0: return a + b;
      3'd1: return a | b;
      3'd2: return a >> b[4:0];
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a - b;
      3'd5: begin
        p = 64'(a) * 64'(b);
        return mulEn ? p[31:0] : 32'd0;
      end
      default: return 32'd0;
    endcase
  endfunction

  // Expected writeback view of a completed instruction (no bubble).
  function automatic outT model(input inT x, input bit mulEn);
    outT e;
    logic [31:0] b;
    b       = x.asrc ? x.immI : x.rd2;
    e.res   = refAlu(x.op, x.rd1, b, mulEn);
    e.zero  = (e.res == 32'd0);
    e.stall = 1'b0;
    e.rw    = x.rw;
    e.wds   = x.wds;
    e.br    = x.br;
    e.cz    = x.cz;
    e.rd    = x.rd;
    e.immU  = x.immU;
    e.pcBr  = x.pc + x.immB;
    e.pc4   = x.pc + 32'd4;
    return e;
  endfunction

  function automatic outT resetOut();
    outT e;
    e.stall = 1'b0; e.rw = 1'b0; e.wds = 1'b0; e.br = 1'b0; e.cz = 1'b0;
    e.zero = 1'b1; e.rd = 5'd0; e.immU = 32'd0; e.res = 32'd0;
    e.pcBr = 32'd0; e.pc4 = 32'd4;
    return e;
  endfunction

  function automatic inT mk(input logic [2:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic asrc, input logic [31:0] immI, input logic [4:0] rd,
                            input logic rw);
    inT x;
    x.rw = rw; x.wds = 1'b0; x.br = 1'b0; x.cz = 1'b0; x.asrc = asrc; x.op = op;
    x.rd = rd; x.rd1 = rd1; x.rd2 = rd2; x.immI = immI; x.immB = 32'd0;
    x.immU = 32'd0; x.pc = 32'd0;
    return x;
  endfunction

  function automatic inT rnd(input bit allowMul);
    inT x;
    x.rw = 1'($urandom); x.wds = 1'($urandom); x.br = 1'($urandom); x.cz = 1'($urandom);
    x.asrc = 1'($urandom);
    x.op = 3'($urandom_range(0, 7));
    if (!allowMul && x.op == 3'd5) x.op = 3'd0;
    x.rd = 5'($urandom); x.rd1 = $urandom; x.rd2 = $urandom; x.immI = $urandom;
    x.immB = $urandom; x.immU = $urandom; x.pc = $urandom;
    if ($urandom_range(0, 3) == 0) x.rd2 = x.rd1;
    return x;
  endfunction

  task automatic drive(input bit sel, input inT x);
    if (!sel) begin
      ifc.regWrite_i = x.rw; ifc.wdSrc_i = x.wds; ifc.branch_i = x.br; ifc.condZero_i = x.cz;
      ifc.aluSrc_i = x.asrc; ifc.aluControl_i = x.op; ifc.rd_i = x.rd; ifc.rd1_i = x.rd1;
      ifc.rd2_i = x.rd2; ifc.immI_i = x.immI; ifc.immB_i = x.immB; ifc.immU_i = x.immU;
      ifc.pc_i = x.pc;
    end else begin
      ifc0.regWrite_i = x.rw; ifc0.wdSrc_i = x.wds; ifc0.branch_i = x.br; ifc0.condZero_i = x.cz;
      ifc0.aluSrc_i = x.asrc; ifc0.aluControl_i = x.op; ifc0.rd_i = x.rd; ifc0.rd1_i = x.rd1;
      ifc0.rd2_i = x.rd2; ifc0.immI_i = x.immI; ifc0.immB_i = x.immB; ifc0.immU_i = x.immU;
      ifc0.pc_i = x.pc;
    end
  endtask

  task automatic sample(input bit sel, output outT o);
    if (!sel) begin
      o.stall = ifc.stall_o; o.rw = ifc.regWrite_o; o.wds = ifc.wdSrc_o; o.br = ifc.branch_o;
      o.cz = ifc.condZero_o; o.zero = ifc.aluZero_o; o.rd = ifc.rd_o; o.immU = ifc.immU_o;
      o.res = ifc.aluResult_o; o.pcBr = ifc.pcBranch_o; o.pc4 = ifc.pcPlus4_o;
    end else begin
      o.stall = ifc0.stall_o; o.rw = ifc0.regWrite_o; o.wds = ifc0.wdSrc_o; o.br = ifc0.branch_o;
      o.cz = ifc0.condZero_o; o.zero = ifc0.aluZero_o; o.rd = ifc0.rd_o; o.immU = ifc0.immU_o;
      o.res = ifc0.aluResult_o; o.pcBr = ifc0.pcBranch_o; o.pc4 = ifc0.pcPlus4_o;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkOut(input string tag, input bit sel, input outT e);
    outT o;
    sample(sel, o);
    chk({tag, ".stall"},     32'(o.stall), 32'(e.stall));
    chk({tag, ".regWrite"},  32'(o.rw),    32'(e.rw));
    chk({tag, ".wdSrc"},     32'(o.wds),   32'(e.wds));
    chk({tag, ".branch"},    32'(o.br),    32'(e.br));
    chk({tag, ".condZero"},  32'(o.cz),    32'(e.cz));
    chk({tag, ".aluZero"},   32'(o.zero),  32'(e.zero));
    chk({tag, ".rd"},        32'(o.rd),    32'(e.rd));
    chk({tag, ".immU"},      o.immU,       e.immU);
    chk({tag, ".aluResult"}, o.res,        e.res);
    chk({tag, ".pcBranch"},  o.pcBr,       e.pcBr);
    chk({tag, ".pcPlus4"},   o.pc4,        e.pc4);
  endtask

  // Issue one instruction to the MUL_EN=1 instance and check its result cycle.
  // While a MUL stalls, unrelated junk is driven on the inputs to prove the hold.
  task automatic runOp(input string tag, input inT x);
    int   cycles;
    logic maskBad;
    drive(1'b0, x);
    @(posedge clk); #1;
    if (x.op == 3'd5) begin
      cycles  = 0;
      maskBad = 1'b0;
      while (ifc.stall_o === 1'b1 && cycles < 40) begin
        if (ifc.regWrite_o !== 1'b0 || ifc.branch_o !== 1'b0) maskBad = 1'b1;
        drive(1'b0, rnd(1'b1));
        cycles++;
        @(posedge clk); #1;
      end
      chk({tag, ".stallCycles"}, 32'(cycles), 32'd33);
      chk({tag, ".bubbleMask"},  32'(maskBad), 32'd0);
    end
    chkOut(tag, 1'b0, model(x, 1'b1));
  endtask

  task automatic runOp0(input string tag, input inT x);
    drive(1'b1, x);
    @(posedge clk); #1;
    chkOut(tag, 1'b1, model(x, 1'b0));
  endtask

  initial begin
    inT x;
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    drive(1'b0, mk(3'd0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b0));
    drive(1'b1, mk(3'd0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    chkOut("reset", 1'b0, resetOut());
    chkOut("reset0", 1'b1, resetOut());
    rst = 1'b0;

    // directed single-cycle ops
    runOp("add", mk(3'd0, 32'd5, 32'd7, 1'b0, 32'd0, 5'd3, 1'b1));
    runOp("srl", mk(3'd2, 32'h8000_0000, 32'd0, 1'b1, 32'd4, 5'd4, 1'b1));
    runOp("sltu1", mk(3'd3, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0, 5'd5, 1'b1));
    runOp("sltu0", mk(3'd3, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 5'd6, 1'b1));
    runOp("or", mk(3'd1, 32'hF0F0_0000, 32'h0000_0F0F, 1'b0, 32'd0, 5'd7, 1'b1));
    runOp("op7", mk(3'd7, 32'd3, 32'd4, 1'b0, 32'd0, 5'd8, 1'b1));
    x = mk(3'd4, 32'd9, 32'd9, 1'b0, 32'd0, 5'd0, 1'b0);
    x.pc = 32'h100; x.immB = 32'hFFFF_FFF8; x.br = 1'b1; x.cz = 1'b1;
    runOp("branch", x);

    // MUL, then ADD right after
    runOp("mul", mk(3'd5, 32'h0001_2345, 32'h100, 1'b0, 32'd0, 5'd9, 1'b1));
    runOp("addAfterMul", mk(3'd0, 32'd20, 32'd22, 1'b0, 32'd0, 5'd10, 1'b1));
    runOp("mulMax", mk(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 5'd11, 1'b1));
    runOp("mulImm", mk(3'd5, 32'd1000, 32'd99, 1'b1, 32'd77, 5'd12, 1'b1));
    runOp("mulBackToBack", mk(3'd5, 32'h8000_0001, 32'd3, 1'b0, 32'd0, 5'd13, 1'b1));

    // reset during the 10th BUSY cycle of a MUL
    drive(1'b0, mk(3'd5, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'd0, 5'd14, 1'b1));
    @(posedge clk); #1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("midMul.stallBefore", 32'(ifc.stall_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chkOut("midMulReset", 1'b0, resetOut());
    rst = 1'b0;
    runOp("addAfterReset", mk(3'd0, 32'd100, 32'd23, 1'b0, 32'd0, 5'd15, 1'b1));

    // MUL_EN=0 instance: MUL yields 0 with no stall or bubble
    runOp0("mulOff", mk(3'd5, 32'h0001_2345, 32'h100, 1'b0, 32'd0, 5'd9, 1'b1));
    runOp0("mulOff2", mk(3'd5, 32'd3, 32'd5, 1'b1, 32'd7, 5'd2, 1'b1));
    runOp0("addOff", mk(3'd0, 32'd5, 32'd7, 1'b0, 32'd0, 5'd3, 1'b1));

    // randomized ops against the model, occasional MULs
    for (int i = 0; i < 40; i++) begin
      runOp($sformatf("rnd%0d", i), rnd(i % 8 == 3));
    end
    for (int i = 0; i < 10; i++) begin
      runOp0($sformatf("rnd0_%0d", i), rnd(1'b1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/execute.md
# execute

Execute stage of the pipelined schoolRISCV core: sits between decode and `writeback`, registers the decoded instruction, computes the ALU result, branch target and PC+4, and presents them on the exact signal set `writeback` captures. Single-cycle ops complete in one stage cycle. MUL is iterative shift-add over multiple cycles, stalling upstream via `stall_o` and inserting bubbles toward `writeback`.

## Interface
Parameters:
- `MUL_EN`, default 1: enables iterative MUL (aluControl 3'b101). When 0, MUL yields 0 and never stalls.

Ports:
- `clk`  in  1  single clock, all state updates on posedge
- `rst`  in  1  reset, synchronous, active-high
- `regWrite_i`, `wdSrc_i`, `branch_i`, `condZero_i`, `aluSrc_i`  in  1 each  decoded controls
- `aluControl_i`  in  3  000 ADD, 001 OR, 010 SRL, 011 SLTU, 100 SUB, 101 MUL, others → result 0
- `rd_i`  in  5  destination register
- `rd1_i`, `rd2_i`, `immI_i`, `immB_i`, `immU_i`, `pc_i`  in  32 each  operands, immediates, instruction PC
- `stall_o`  out  1  upstream must hold all `*_i` and PC while high
- `regWrite_o`, `wdSrc_o`, `branch_o`, `condZero_o`, `aluZero_o`  out  1 each
- `rd_o`  out  5
- `immU_o`, `aluResult_o`, `pcBranch_o`, `pcPlus4_o`  out  32 each

## Operation
- Stage register captures every `*_i` on posedge when `stall_o`=0; holds when `stall_o`=1.
- srcA = rd1; srcB = aluSrc ? immI : rd2 (all from stage register).
- ADD/SUB mod 2^32; OR bitwise; SRL logical, shamt = srcB[4:0]; SLTU unsigned compare, result 0/1.
- `aluZero_o` = (aluResult_o == 0). `pcBranch_o` = pc + immB; `pcPlus4_o` = pc + 4, both mod 2^32.
- `regWrite_o`, `wdSrc_o`, `branch_o`, `condZero_o`, `rd_o`, `immU_o` pass straight from the stage register, except that during a bubble `regWrite_o`=0 and `branch_o`=0.
- MUL FSM, states IDLE/BUSY/DONE:
  - IDLE: stage reg holds MUL (MUL_EN=1) → `stall_o`=1, bubble; next posedge → BUSY, acc=0, mcand=srcA, mplier=srcB, cnt=0.
  - BUSY: `stall_o`=1, bubble. Each posedge: if mplier[0], acc += mcand; mcand <<= 1; mplier >>= 1; cnt++. At the posedge with cnt==31 → DONE.
  - DONE: `stall_o`=0; `aluResult_o` = acc (low 32 bits of product); controls not masked. Next posedge → IDLE, and the stage reg captures the next instruction.
  - Non-MUL ops never leave IDLE.
- No forwarding or hazard detection in this block. Flush is out of scope.

## Timing
- Single-cycle op captured at edge N: outputs valid from after edge N until edge N+1. `writeback` registers them at edge N+1.
- MUL captured at edge N: `stall_o`=1 from edge N to edge N+33 (33 cycles: 1 IDLE + 32 BUSY). DONE is cycle N+33 to N+34, with `stall_o`=0 and the result valid. The next instruction is captured at edge N+34.
- `stall_o` is combinational from FSM state and the stage-register opcode. It has no dependence on `*_i`.
- Reset (`rst`=1 at posedge):
  - Stage register zeroes, FSM → IDLE, cnt/acc zero.
  - Outputs after reset: `stall_o`=0, `regWrite_o`=0, `branch_o`=0, `wdSrc_o`=0, `condZero_o`=0, `rd_o`=0, `immU_o`=0, `aluResult_o`=0, `aluZero_o`=1, `pcBranch_o`=0, `pcPlus4_o`=4.
- Reset mid-MUL (IDLE-with-MUL, BUSY or DONE): aborts. No writeback is issued for the aborted MUL. Reset outputs as above next cycle.
- Reset wins over the stall hold and over capture.
- Back-to-back MULs: each takes the full 34 cycles. No overlap.

## Test plan
- Reset: hold `rst`=1 for 2 cycles → `stall_o`=0, `regWrite_o`=0, `branch_o`=0, `aluResult_o`=0, `aluZero_o`=1, `pcPlus4_o`=4.
- ADD: rd1=5, rd2=7, aluSrc=0, op=000, rd=3, regWrite=1 → one edge later `aluResult_o`=12, `aluZero_o`=0, `rd_o`=3, `regWrite_o`=1, `stall_o`=0.
- SRL/SLTU:
  - rd1=0x80000000, immI=4, aluSrc=1, SRL → 0x08000000.
  - Next cycle SLTU, rd1=1, rd2=0xFFFFFFFF → 1.
  - SLTU, rd1=0xFFFFFFFF, rd2=1 → 0 with `aluZero_o`=1.
- Branch: pc=0x100, immB=0xFFFFFFF8, SUB, rd1=rd2=9, branch=1, condZero=1 → `aluZero_o`=1, `pcBranch_o`=0xF8, `pcPlus4_o`=0x104, `branch_o`=1, `condZero_o`=1.
- MUL:
  - Stimulus: rd1=0x00012345, rd2=0x100, then ADD held on inputs.
  - Required: `stall_o`=1 for exactly 33 cycles with `regWrite_o`=0 and `branch_o`=0 throughout. Then one cycle with `aluResult_o`=0x01234500 and `regWrite_o`=1. Then the ADD result on the following cycle.
  - Also: 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
- Reset mid-MUL: assert `rst` on the 10th BUSY cycle → next cycle IDLE, `stall_o`=0, `regWrite_o`=0. A subsequent ADD completes normally.
- MUL_EN=0: MUL → `stall_o` never rises, `aluResult_o`=0.
